// File: rtl/msk_pkg.sv
// Shared definitions for the differential MSK/FSK detector.
//   SPS_DEF / MID_DEF / DATA_W_DEF : default symbol timing and sample width
//   CNT_W                          : sample counter width for the default SPS
//   iq_t                           : one complex baseband sample at default width
//   sat_shift()                    : arithmetic right shift followed by signed saturation
package msk_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int SPS_DEF    = 20;
    localparam int MID_DEF    = 10;
    localparam int CNT_W      = $clog2(SPS_DEF);

    typedef struct packed {
        logic signed [DATA_W_DEF-1:0] i;
        logic signed [DATA_W_DEF-1:0] q;
    } iq_t;

    // Shift 'value' right arithmetically by 'shift', then clamp into the signed
    // range of a 'width'-bit number. Result is returned sign-extended to 64 bits.
    function automatic logic signed [63:0] sat_shift(
        input logic signed [63:0] value,
        input int unsigned        shift,
        input int unsigned        width
    );
        logic signed [63:0] v;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        v  = value >>> shift;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/msk_xprod_pipe.sv
// Cross-product datapath: diff = cur_q*prev_i - cur_i*prev_q.
// Kept separate so the multiplies can be mapped onto DSP macros without
// disturbing the symbol timing/control around it.
//   clk, reset_n          : clock, asynchronous active-low reset
//   in_valid              : token present on cur_* / prev_* this cycle
//   cur_i/q, prev_i/q     : current and previous symbol samples (signed)
//   diff, diff_valid      : signed cross product, two cycles after in_valid
module msk_xprod_pipe #(
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] cur_i,
    input  logic signed [DATA_W-1:0] cur_q,
    input  logic signed [DATA_W-1:0] prev_i,
    input  logic signed [DATA_W-1:0] prev_q,
    output logic signed [2*DATA_W:0] diff,
    output logic                     diff_valid
);

    localparam int PW = 2 * DATA_W;

    logic signed [PW-1:0] cq_x, ci_x, pi_x, pq_x;
    logic signed [PW-1:0] p_a, p_b;
    logic signed [PW:0]   pa_x, pb_x;
    logic                 s1_valid;

    always_comb begin
        cq_x = PW'(cur_q);
        ci_x = PW'(cur_i);
        pi_x = PW'(prev_i);
        pq_x = PW'(prev_q);
        pa_x = (PW + 1)'(p_a);
        pb_x = (PW + 1)'(p_b);
    end

    // Free-running stages; the valid bit travels with the data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_a        <= '0;
            p_b        <= '0;
            s1_valid   <= 1'b0;
            diff       <= '0;
            diff_valid <= 1'b0;
        end else begin
            p_a        <= cq_x * pi_x;
            p_b        <= ci_x * pq_x;
            s1_valid   <= in_valid;
            diff       <= pa_x - pb_x;
            diff_valid <= s1_valid;
        end
    end

endmodule

// File: rtl/msk_diff_demod.sv
// Differential MSK/FSK detector. Picks one sample per symbol at an adjustable
// phase and emits the sign and a saturated, scaled copy of Im(cur*conj(prev)).
//   clk, reset_n : clock, asynchronous active-low reset
//   in_valid     : i_in/q_in carry a sample this cycle
//   i_in, q_in   : signed baseband samples
//   phase_adj    : signed offset to MID_DEFAULT, applied at the next symbol
//   sym_strobe   : registered sample-point pulse (debug)
//   data_out     : hard decision, held between valids
//   soft_out     : saturated soft decision, held between valids
//   out_valid    : one-cycle pulse per emitted symbol
//   sym_count    : emitted symbol count, wraps at 2^16
module msk_diff_demod
    import msk_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SPS         = SPS_DEF,
    parameter int MID_DEFAULT = MID_DEF,
    parameter int ADJ_W       = 8,
    parameter int SOFT_W      = 8,
    parameter int SOFT_SHIFT  = 16,
    parameter int INVERT      = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] i_in,
    input  logic signed [DATA_W-1:0] q_in,
    input  logic signed [ADJ_W-1:0]  phase_adj,
    output logic                     sym_strobe,
    output logic                     data_out,
    output logic signed [SOFT_W-1:0] soft_out,
    output logic                     out_valid,
    output logic [15:0]              sym_count
);

    localparam int   CNT_BITS = $clog2(SPS);
    localparam int   SUM_W    = ((ADJ_W > CNT_BITS) ? ADJ_W : CNT_BITS) + 2;
    localparam logic INV_BIT  = (INVERT != 0);

    logic [CNT_BITS-1:0]     cnt;
    logic [CNT_BITS-1:0]     phase_q;
    logic [CNT_BITS-1:0]     phase_next;
    logic signed [SUM_W-1:0] phase_sum;
    logic                    cnt_last;
    logic                    strb;
    logic signed [DATA_W-1:0] cur_i;
    logic signed [DATA_W-1:0] cur_q;
    logic                    prev_ok;
    logic signed [2*DATA_W:0] diff;
    logic                    diff_valid;

    always_comb begin
        phase_sum = SUM_W'(MID_DEFAULT) + SUM_W'(phase_adj);
        if (phase_sum[SUM_W-1]) begin
            phase_next = '0;
        end else if (phase_sum > SUM_W'(SPS - 1)) begin
            phase_next = CNT_BITS'(SPS - 1);
        end else begin
            phase_next = phase_sum[CNT_BITS-1:0];
        end
        cnt_last = (cnt == CNT_BITS'(SPS - 1));
        strb     = in_valid && (cnt == phase_q);
    end

    // Phase only reloads on the last sample of a symbol, so an adjustment
    // never produces a second or a missing strobe inside the current symbol.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            phase_q    <= CNT_BITS'(MID_DEFAULT);
            cur_i      <= '0;
            cur_q      <= '0;
            prev_ok    <= 1'b0;
            sym_strobe <= 1'b0;
        end else begin
            sym_strobe <= strb;
            if (in_valid) begin
                if (cnt_last) begin
                    cnt     <= '0;
                    phase_q <= phase_next;
                end else begin
                    cnt <= cnt + CNT_BITS'(1);
                end
            end
            if (strb) begin
                cur_i   <= i_in;
                cur_q   <= q_in;
                prev_ok <= 1'b1;
            end
        end
    end

    // The live input is the current symbol and the stored sample is the
    // previous one, so the multiply stage starts in the strobe cycle itself
    // and no separate prev register is needed.
    msk_xprod_pipe #(
        .DATA_W (DATA_W)
    ) u_xprod (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (strb && prev_ok),
        .cur_i      (i_in),
        .cur_q      (q_in),
        .prev_i     (cur_i),
        .prev_q     (cur_q),
        .diff       (diff),
        .diff_valid (diff_valid)
    );

    // Output stage: hard/soft decisions are registered here, giving three
    // cycles from the strobe cycle to out_valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out  <= 1'b0;
            soft_out  <= '0;
            out_valid <= 1'b0;
            sym_count <= '0;
        end else begin
            out_valid <= diff_valid;
            if (diff_valid) begin
                data_out  <= ~diff[2*DATA_W] ^ INV_BIT;
                soft_out  <= SOFT_W'(sat_shift(64'(diff), SOFT_SHIFT, SOFT_W));
                sym_count <= sym_count + 16'd1;
            end
        end
    end

endmodule
